// File: rtl/spi_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter_pkg
//   Shared constants for the SPI bus arbiter:
//   - FSM state encodings (3 bits, legacy-compatible localparams)
//   - SPI mode constants (mode 0: CPOL=0, CPHA=0)
//   - default parameter values
//   - cnt_w(): counter width helper that never returns 0
// ---------------------------------------------------------------------------
package spi_bus_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // SPI mode 0: clock idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int DEF_N_REQ   = 2;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_CS_GAP  = 2;

  // Width able to hold 0..max_count-1; at least 1 so a count of 1 stays legal.
  function automatic int cnt_w(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter_rr_arbiter
//   Purely combinational round-robin pick. Scans requests starting at
//   i_rr_ptr+1 and wrapping, so the last winner has the lowest priority.
// Ports
//   i_req     N_REQ  level requests
//   i_rr_ptr  PTR_W  index of the previous winner
//   o_onehot  N_REQ  one-hot winner (0 when no request)
//   o_idx     PTR_W  binary index of the winner
//   o_any     1      at least one request present
// ---------------------------------------------------------------------------
module spi_bus_arbiter_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    // Offset 1 first so the current owner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = int'(i_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!o_any && i_req[idx]) begin
        o_any         = 1'b1;
        o_onehot[idx] = 1'b1;
        o_idx         = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter
//   Shares one SPI slave bus between N_REQ on-chip requesters. Each grant
//   runs exactly one full-duplex DATA_W-bit frame, MSB first, SPI mode 0.
//   FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// Configuration
//   SPI_LOOPBACK_EN : internal MISO is taken from spi_mosi and spi_miso is
//                     ignored; pins and timing are unchanged.
// Ports
//   clock     in   system clock, posedge
//   reset     in   asynchronous, active-high
//   req       in   [N_REQ]         level request, held until matching done
//   tx_data   in   [N_REQ*DATA_W]  requester i byte at [i*DATA_W +: DATA_W]
//   grant     out  [N_REQ]         one-hot owner of current frame
//   done      out  [N_REQ]         1-cycle pulse to owner at frame end
//   rx_data   out  [DATA_W]        last captured MISO frame
//   busy      out  high whenever the FSM is not IDLE
//   spi_sclk  out  SPI clock (idle low)
//   spi_mosi  out  serial out
//   spi_miso  in   serial in
//   spi_cs_n  out  active-low chip select
//   dbg_state out  [3] current FSM state (ST_* encoding)
// Handshake: a requester holds req high until it sees its done bit; tx_data
// for that requester is captured on the edge grant rises and ignored after.
// ---------------------------------------------------------------------------
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_GAP  = DEF_CS_GAP
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] tx_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    busy,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    spi_cs_n,
  output logic [2:0]              dbg_state
);

  localparam int PTR_W  = cnt_w(N_REQ);
  localparam int CNT_W  = cnt_w((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam int HALF_W = cnt_w(2 * DATA_W);

  logic [2:0]        r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_done;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_shift;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_cs_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [HALF_W-1:0] r_half;

  logic [N_REQ-1:0]  w_onehot;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [DATA_W-1:0] w_tx;
  logic              w_miso;
  logic              w_div_last;
  logic              w_gap_last;
  logic              w_half_last;

  spi_bus_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Winner's transmit byte, selected by index compare rather than a multiply.
  always_comb begin
    w_tx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == PTR_W'(i)) w_tx = tx_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef SPI_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = spi_miso;
  assign w_miso        = r_mosi;
`else
  assign w_miso = spi_miso;
`endif

  assign w_div_last  = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_gap_last  = (r_cnt == CNT_W'(CS_GAP - 1));
  assign w_half_last = (r_half == HALF_W'(2 * DATA_W - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= PTR_W'(N_REQ - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_rx_data <= '0;
      r_shift   <= '0;
      r_sclk    <= SPI_CPOL;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_cnt     <= '0;
      r_half    <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= w_onehot;
            r_rr_ptr <= w_idx;
            r_shift  <= w_tx;
            r_mosi   <= w_tx[DATA_W-1];
            r_cs_n   <= 1'b0;
            r_cnt    <= '0;
            r_half   <= '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_div_last) begin
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_div_last) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_half <= r_half + 1'b1;
            if (!r_sclk) begin
              // Rising edge: sample MISO into the LSB.
              r_shift <= {r_shift[DATA_W-2:0], w_miso};
            end else if (w_half_last) begin
              // Last falling edge: MOSI stays put, frame body is finished.
              r_state <= ST_HOLD;
            end else begin
              // Falling edge: the shift on the preceding rise already moved
              // the next outgoing bit into the MSB.
              r_mosi <= r_shift[DATA_W-1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_div_last) begin
            r_cnt     <= '0;
            r_cs_n    <= 1'b1;
            r_grant   <= '0;
            r_done    <= r_grant;
            r_rx_data <= r_shift;
            r_state   <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_gap_last) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state != ST_IDLE);
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;
  assign spi_cs_n  = r_cs_n;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_bus_arbiter
//   Directed bench for spi_bus_arbiter. A default instance (N_REQ=2,
//   CLK_DIV=2) runs a vector table plus multi-cycle sequences; a second
//   instance (N_REQ=4, CLK_DIV=1) checks four-way rotation and fast timing.
//   Build with SPI_LOOPBACK_EN defined to check the loopback variant.
// ---------------------------------------------------------------------------
module tb_spi_bus_arbiter;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- default instance ----------------
  logic [1:0]  req;
  logic [15:0] tx_data;
  logic [1:0]  grant, done;
  logic [7:0]  rx_data;
  logic        busy, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic [2:0]  dbg_state;

  spi_bus_arbiter #(.N_REQ(2), .DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) dut (
    .clock(clock), .reset(reset), .req(req), .tx_data(tx_data),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .dbg_state(dbg_state)
  );

  // ---------------- four-requester fast instance ----------------
  logic [3:0]  req_4;
  logic [31:0] tx_4;
  logic [3:0]  grant_4, done_4;
  logic [7:0]  rx_4;
  logic        busy_4, sclk_4, mosi_4, miso_4, cs_n_4;
  logic [2:0]  dbg_4;

  spi_bus_arbiter #(.N_REQ(4), .DATA_W(8), .CLK_DIV(1), .CS_GAP(2)) dut4 (
    .clock(clock), .reset(reset), .req(req_4), .tx_data(tx_4),
    .grant(grant_4), .done(done_4), .rx_data(rx_4), .busy(busy_4),
    .spi_sclk(sclk_4), .spi_mosi(mosi_4), .spi_miso(miso_4),
    .spi_cs_n(cs_n_4), .dbg_state(dbg_4)
  );

  // ---------------- slave model (mode 0) ----------------
  // Presents s_rsp MSB first: bit 7 while CS_n is high, next bit after each fall.
  logic [7:0] s_rsp = 8'h00;
  logic [2:0] s_idx = 3'd7;
  logic       s_prev = 1'b0;

  always @(negedge clock) begin
    if (spi_cs_n) s_idx = 3'd7;
    else if (s_prev && !spi_sclk && s_idx != 3'd0) s_idx = s_idx - 3'd1;
    s_prev = spi_sclk;
  end

`ifdef SPI_LOOPBACK_EN
  always @(negedge clock) spi_miso = 1'($urandom_range(0, 1));
`else
  always_comb spi_miso = s_rsp[s_idx];
`endif

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int hi_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] rsp);
    return LOOPBACK ? tx : rsp;
  endfunction

  // Runs one frame on the default instance from the current negedge.
  // exp_gap < 0 skips the CS_n-high check; drop_at > 0 drops req that many
  // cycles after grant.
  task automatic wait_frame(input string tag, input logic [1:0] exp_g,
                            input logic [7:0] exp_tx, input logic [7:0] rsp,
                            input int exp_gap, input int drop_at);
    int n, lat, rises, first_r, last_r;
    logic prev;
    logic [7:0] cap;
    logic [15:0] tx_save;
    s_rsp = rsp;
    n = 0;
    while (grant == 2'b00 && n < 200) begin
      @(negedge clock);
      n++;
      if (spi_cs_n) hi_cnt++;
    end
    check({tag, "_grant_seen"}, 32'(|grant), 32'd1);
    check({tag, "_grant"}, 32'(grant), 32'(exp_g));
    if (exp_gap >= 0) check({tag, "_cs_gap"}, 32'(hi_cnt), 32'(exp_gap));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cs_low"}, 32'(spi_cs_n), 32'd0);
    // Changing tx_data after grant must not affect the frame.
    tx_save = tx_data;
    tx_data = ~tx_data;
    lat = 0; rises = 0; first_r = 0; last_r = 0; cap = 8'h00;
    prev = spi_sclk;
    while (done == 2'b00 && lat < 200) begin
      @(negedge clock);
      lat++;
      if (lat == drop_at) req = 2'b00;
      if (!prev && spi_sclk) begin
        cap = {cap[6:0], spi_mosi};
        if (rises == 0) first_r = lat;
        last_r = lat;
        rises++;
      end
      prev = spi_sclk;
    end
    tx_data = tx_save;
    check({tag, "_done_seen"}, 32'(|done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd36);
    check({tag, "_done"}, 32'(done), 32'(exp_g));
    check({tag, "_rx"}, 32'(rx_data), 32'(exp_rx(exp_tx, rsp)));
    check({tag, "_mosi"}, 32'(cap), 32'(exp_tx));
    check({tag, "_rises"}, 32'(rises), 32'd8);
    check({tag, "_sclk_span"}, 32'(last_r - first_r), 32'd28);
    check({tag, "_grant_clr"}, 32'(grant), 32'd0);
    check({tag, "_cs_high"}, 32'(spi_cs_n), 32'd1);
    check({tag, "_busy_gap"}, 32'(busy), 32'd1);
    hi_cnt = spi_cs_n ? 1 : 0;
    @(negedge clock);
    if (spi_cs_n) hi_cnt++;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] req;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [7:0] rsp;
    logic [1:0] exp_g;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] exp_g4[5];
  logic [7:0] exp_tx4[5];

  initial begin : main
    int n, rises;
    logic prev;
    int lat, first_r, last_r;
    logic [3:0] g;

    // Round-robin pointer starts at 1 after reset, so requester 0 is first.
    vecs[0] = '{req: 2'b01, tx0: 8'hA5, tx1: 8'h00, rsp: 8'h3C, exp_g: 2'b01, exp_tx: 8'hA5};
    vecs[1] = '{req: 2'b10, tx0: 8'h00, tx1: 8'h5A, rsp: 8'hC3, exp_g: 2'b10, exp_tx: 8'h5A};
    vecs[2] = '{req: 2'b11, tx0: 8'hFF, tx1: 8'h00, rsp: 8'h00, exp_g: 2'b01, exp_tx: 8'hFF};
    vecs[3] = '{req: 2'b11, tx0: 8'h01, tx1: 8'h80, rsp: 8'hFF, exp_g: 2'b10, exp_tx: 8'h80};
    vecs[4] = '{req: 2'b01, tx0: 8'h80, tx1: 8'h7E, rsp: 8'h01, exp_g: 2'b01, exp_tx: 8'h80};
    vecs[5] = '{req: 2'b10, tx0: 8'h00, tx1: 8'h69, rsp: 8'h96, exp_g: 2'b10, exp_tx: 8'h69};
    exp_g4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_tx4 = '{8'h10, 8'h21, 8'h42, 8'h84, 8'h10};

    reset = 1'b1; req = 2'b00; tx_data = 16'h0000;
    req_4 = 4'h0; tx_4 = 32'h0; miso_4 = 1'b1;
    repeat (3) @(negedge clock);

    // Reset values.
    check("rst_grant",   32'(grant),     32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_rx",      32'(rx_data),   32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_sclk",    32'(spi_sclk),  32'd0);
    check("rst_mosi",    32'(spi_mosi),  32'd0);
    check("rst_cs_n",    32'(spi_cs_n),  32'd1);
    check("rst_state",   32'(dbg_state), 32'd0);
    check("rst4_grant",  32'(grant_4),   32'd0);
    check("rst4_cs_n",   32'(cs_n_4),    32'd1);
    reset = 1'b0;
    @(negedge clock);

    // Table: one frame per vector, requests dropped after done.
    for (int i = 0; i < 6; i++) begin
      tx_data = {vecs[i].tx1, vecs[i].tx0};
      req     = vecs[i].req;
      wait_frame($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_tx, vecs[i].rsp, -1, -1);
      req = 2'b00;
      wait_idle($sformatf("vec%0d", i));
    end

    // Both requests held from reset: 0, 1, 0 with CS_GAP+1 high cycles between.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tx_data = {8'h22, 8'h11};
    req = 2'b11;
    wait_frame("rr1", 2'b01, 8'h11, 8'h3C, -1, -1);
    wait_frame("rr2", 2'b10, 8'h22, 8'h3C, 3, -1);
    wait_frame("rr3", 2'b01, 8'h11, 8'h3C, 3, -1);
    req = 2'b00;
    wait_idle("rr");

    // Request dropped 5 cycles into the frame: frame still completes.
    tx_data = {8'h00, 8'h5C};
    req = 2'b01;
    wait_frame("drop", 2'b01, 8'h5C, 8'hA6, -1, 5);
    repeat (20) @(negedge clock);
    check("drop_no_regrant", 32'(grant),    32'd0);
    check("drop_idle",       32'(busy),     32'd0);
    check("drop_cs_n",       32'(spi_cs_n), 32'd1);

    // Reset while bit 3 is on the wire (fifth rising edge).
    tx_data = {8'h00, 8'hE7};
    s_rsp = 8'h5A;
    req = 2'b01;
    n = 0;
    while (grant == 2'b00 && n < 200) begin @(negedge clock); n++; end
    check("mid_grant", 32'(grant), 32'd1);
    rises = 0;
    prev = spi_sclk;
    while (rises < 5 && n < 400) begin
      @(negedge clock);
      n++;
      if (!prev && spi_sclk) rises++;
      prev = spi_sclk;
    end
    check("mid_state_shift", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    #1;
    check("mid_cs_n",  32'(spi_cs_n),  32'd1);
    check("mid_sclk",  32'(spi_sclk),  32'd0);
    check("mid_grant0",32'(grant),     32'd0);
    check("mid_done",  32'(done),      32'd0);
    check("mid_busy",  32'(busy),      32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check("mid_rx_clr", 32'(rx_data), 32'd0);
    wait_frame("clean", 2'b01, 8'hE7, 8'h5A, -1, -1);
    req = 2'b00;
    wait_idle("clean");

    // Four requesters, CLK_DIV=1: rotation 0,1,2,3,0 and 18-cycle frames.
    tx_4  = {8'h84, 8'h42, 8'h21, 8'h10};
    req_4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant_4 == 4'h0 && n < 100) begin @(negedge clock); n++; end
      check($sformatf("q%0d_grant", k), 32'(grant_4), 32'(exp_g4[k]));
      g = grant_4;
      lat = 0; rises = 0; first_r = 0; last_r = 0;
      prev = sclk_4;
      while (done_4 == 4'h0 && lat < 100) begin
        @(negedge clock);
        lat++;
        if (!prev && sclk_4) begin
          if (rises == 0) first_r = lat;
          last_r = lat;
          rises++;
        end
        prev = sclk_4;
      end
      check($sformatf("q%0d_latency", k), 32'(lat), 32'd18);
      check($sformatf("q%0d_done", k), 32'(done_4), 32'(g));
      check($sformatf("q%0d_rx", k), 32'(rx_4), 32'(exp_rx(exp_tx4[k], 8'hFF)));
      check($sformatf("q%0d_rises", k), 32'(rises), 32'd8);
      check($sformatf("q%0d_sclk_span", k), 32'(last_r - first_r), 32'd14);
      @(negedge clock);
    end
    req_4 = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
